// File: rtl/window_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// window_ctrl_pkg
//   Shared definitions for the window_buffer frame sequencer: FSM state
//   encoding, stride field width and the stride normalisation helper.
// -----------------------------------------------------------------------------
package window_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int STRIDE_W = 4;

    // A stride of 0 has no meaning; it behaves as a stride of 1.
    function automatic logic [STRIDE_W-1:0] norm_stride(input logic [STRIDE_W-1:0] s);
        return (s == '0) ? STRIDE_W'(1) : s;
    endfunction

endpackage

// File: rtl/window_ctrl_pos_counter.sv
// -----------------------------------------------------------------------------
// win_pos_counter
//   Raster position tracker for the frame sequencer. Keeps the row/col of the
//   pixel about to be accepted, plus per-axis stride phase counters, and flags
//   whether that pixel completes an in-bounds window on the stride grid.
//
//   clk, rst     clock, synchronous active-high reset
//   clear        return to (0,0) for a new frame
//   advance      a pixel is accepted this cycle; step the position
//   width/height latched frame size
//   stride       normalised stride (1..15)
//   row/col      position of the pixel currently presented
//   emit         that pixel is the bottom-right corner of an output window
//   frame_last   that pixel is the last one of the frame
// -----------------------------------------------------------------------------
module win_pos_counter
    import window_ctrl_pkg::*;
#(
    parameter int K_W = 5,
    parameter int K_H = 5,
    parameter int LW  = 10,
    parameter int LH  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                advance,
    input  logic [LW-1:0]       width,
    input  logic [LH-1:0]       height,
    input  logic [STRIDE_W-1:0] stride,
    output logic [LH-1:0]       row,
    output logic [LW-1:0]       col,
    output logic                emit,
    output logic                frame_last
);

    localparam logic [LW-1:0] KW_M1 = LW'(K_W - 1);
    localparam logic [LH-1:0] KH_M1 = LH'(K_H - 1);

    logic [LH-1:0]       row_reg;
    logic [LW-1:0]       col_reg;
    logic [STRIDE_W-1:0] row_phase_reg;
    logic [STRIDE_W-1:0] col_phase_reg;

    logic col_last;
    logic row_last;

    // Phase holds (pos - (K-1)) mod stride once pos >= K-1. While the next
    // position is still at or below K-1 the phase is pinned to 0, so the first
    // full window always lands on phase 0.
    function automatic logic [STRIDE_W-1:0] phase_step(
        input logic                below_k,
        input logic [STRIDE_W-1:0] phase,
        input logic [STRIDE_W-1:0] s
    );
        if (below_k || (phase == STRIDE_W'(s - STRIDE_W'(1))))
            return '0;
        return phase + STRIDE_W'(1);
    endfunction

    assign col_last   = (col_reg == width - LW'(1));
    assign row_last   = (row_reg == height - LH'(1));
    assign frame_last = col_last && row_last;

    assign emit = (row_reg >= KH_M1) && (col_reg >= KW_M1) &&
                  (row_phase_reg == '0) && (col_phase_reg == '0);

    assign row = row_reg;
    assign col = col_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row_reg       <= '0;
            col_reg       <= '0;
            row_phase_reg <= '0;
            col_phase_reg <= '0;
        end else if (advance) begin
            if (col_last) begin
                col_reg       <= '0;
                col_phase_reg <= '0;
                if (row_last) begin
                    row_reg       <= '0;
                    row_phase_reg <= '0;
                end else begin
                    row_reg       <= row_reg + LH'(1);
                    row_phase_reg <= phase_step(row_reg < KH_M1, row_phase_reg, stride);
                end
            end else begin
                col_reg       <= col_reg + LW'(1);
                col_phase_reg <= phase_step(col_reg < KW_M1, col_phase_reg, stride);
            end
        end
    end

endmodule

// File: rtl/window_ctrl.sv
// -----------------------------------------------------------------------------
// window_ctrl
//   Frame sequencer for a KxK sliding-window line buffer (window_buffer).
//   Latches a frame configuration, pulses the buffer initialise, forwards a
//   raster pixel stream into the buffer and marks the cycles at which the
//   buffer output holds a complete, in-bounds window on the stride grid.
//
//   clk, rst                      clock, synchronous active-high reset
//   cfg_start/width/height/stride frame configuration, latched on cfg_start
//   busy, done, cfg_err           frame status (done is a 1-cycle pulse)
//   pix_data/valid/ready          incoming pixel stream
//   wb_initialize/width/datain/datain_valid   drive the window buffer
//   win_valid/row/col             window qualifier aligned to buffer output
//   win_ready                     consumer back-pressure (gates acceptance)
// -----------------------------------------------------------------------------
module window_ctrl
    import window_ctrl_pkg::*;
#(
    parameter int C_KERNEL_WIDTH      = 5,
    parameter int C_KERNEL_HEIGHT     = 5,
    parameter int C_DATAIN_WIDTH      = 16,
    parameter int C_MAX_WINDOW_WIDTH  = 1024,
    parameter int C_MAX_WINDOW_HEIGHT = 1024,
    parameter int C_BUF_LATENCY       = 1,
    localparam int LW = $clog2(C_MAX_WINDOW_WIDTH),
    localparam int LH = $clog2(C_MAX_WINDOW_HEIGHT),
    localparam int DW = C_DATAIN_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic [LW-1:0]       cfg_width,
    input  logic [LH-1:0]       cfg_height,
    input  logic [STRIDE_W-1:0] cfg_stride,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    input  logic [DW-1:0]       pix_data,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic                wb_initialize,
    output logic [LW-1:0]       wb_width,
    output logic [DW-1:0]       wb_datain,
    output logic                wb_datain_valid,
    output logic                win_valid,
    output logic [LH-1:0]       win_row,
    output logic [LW-1:0]       win_col,
    input  logic                win_ready
);

    // One stage to register the pixel into the buffer, then the buffer's own
    // latency until the updated window appears at its output.
    localparam int PIPE_D  = C_BUF_LATENCY + 1;
    localparam int DRAIN_W = $clog2(C_BUF_LATENCY + 2);

    state_t state_reg, state_next;

    logic [LW-1:0]       width_reg;
    logic [LH-1:0]       height_reg;
    logic [STRIDE_W-1:0] stride_reg;
    logic                cfg_err_reg;
    logic [DRAIN_W-1:0]  drain_cnt_reg;
    logic [DW-1:0]       wb_datain_reg;
    logic                wb_datain_valid_reg;

    logic                valid_pipe_reg [PIPE_D];
    logic [LH-1:0]       row_pipe_reg   [PIPE_D];
    logic [LW-1:0]       col_pipe_reg   [PIPE_D];

    logic          start_ok;
    logic          bad_size;
    logic          accept;
    logic [LH-1:0] pos_row;
    logic [LW-1:0] pos_col;
    logic          pos_emit;
    logic          pos_last;

    assign bad_size = (cfg_width < LW'(C_KERNEL_WIDTH)) || (cfg_height < LH'(C_KERNEL_HEIGHT));
    // cfg_start is only honoured between frames.
    assign start_ok = (state_reg == ST_IDLE) && cfg_start;
    assign accept   = pix_valid && pix_ready;

    win_pos_counter #(
        .K_W (C_KERNEL_WIDTH),
        .K_H (C_KERNEL_HEIGHT),
        .LW  (LW),
        .LH  (LH)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_reg == ST_INIT),
        .advance    (accept),
        .width      (width_reg),
        .height     (height_reg),
        .stride     (stride_reg),
        .row        (pos_row),
        .col        (pos_col),
        .emit       (pos_emit),
        .frame_last (pos_last)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        busy          = 1'b0;
        done          = 1'b0;
        wb_initialize = 1'b0;
        pix_ready     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_start) state_next = bad_size ? ST_DONE : ST_INIT;
            end
            ST_INIT: begin
                busy          = 1'b1;
                wb_initialize = 1'b1;
                state_next    = ST_STREAM;
            end
            ST_STREAM: begin
                busy      = 1'b1;
                pix_ready = win_ready;
                if (accept && pos_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt_reg == DRAIN_W'(C_BUF_LATENCY)) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- configuration and drain timer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            width_reg     <= '0;
            height_reg    <= '0;
            stride_reg    <= STRIDE_W'(1);
            cfg_err_reg   <= 1'b0;
            drain_cnt_reg <= '0;
        end else begin
            if (start_ok) begin
                width_reg   <= cfg_width;
                height_reg  <= cfg_height;
                stride_reg  <= norm_stride(cfg_stride);
                cfg_err_reg <= bad_size;
            end
            if (state_reg == ST_DRAIN) drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
            else                       drain_cnt_reg <= '0;
        end
    end

    // ---------------- pixel forward into the buffer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_datain_reg       <= '0;
            wb_datain_valid_reg <= 1'b0;
        end else begin
            wb_datain_valid_reg <= accept;
            if (accept) wb_datain_reg <= pix_data;
        end
    end

    // ---------------- window qualifier delay line ----------------
    // Stage 0 is loaded in the same cycle the pixel enters the buffer input
    // register; the last stage lines up with the buffer's window output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_D; i++) begin
                valid_pipe_reg[i] <= 1'b0;
                row_pipe_reg[i]   <= '0;
                col_pipe_reg[i]   <= '0;
            end
        end else begin
            valid_pipe_reg[0] <= accept && pos_emit;
            row_pipe_reg[0]   <= pos_row;
            col_pipe_reg[0]   <= pos_col;
            for (int i = 1; i < PIPE_D; i++) begin
                valid_pipe_reg[i] <= valid_pipe_reg[i-1];
                row_pipe_reg[i]   <= row_pipe_reg[i-1];
                col_pipe_reg[i]   <= col_pipe_reg[i-1];
            end
        end
    end

    assign cfg_err         = cfg_err_reg;
    assign wb_width        = width_reg;
    assign wb_datain       = wb_datain_reg;
    assign wb_datain_valid = wb_datain_valid_reg;
    assign win_valid       = valid_pipe_reg[PIPE_D-1];
    assign win_row         = row_pipe_reg[PIPE_D-1];
    assign win_col         = col_pipe_reg[PIPE_D-1];

endmodule

// File: tb/tb_window_ctrl.sv
module tb_window_ctrl;
    localparam int KW  = 3;
    localparam int KH  = 3;
    localparam int DW  = 16;
    localparam int LW  = 6;
    localparam int LH  = 6;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic [LW-1:0] cfg_width = '0;
    logic [LH-1:0] cfg_height = '0;
    logic [3:0]    cfg_stride = '0;
    logic          busy, done, cfg_err;
    logic [DW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic          wb_initialize;
    logic [LW-1:0] wb_width;
    logic [DW-1:0] wb_datain;
    logic          wb_datain_valid;
    logic          win_valid;
    logic [LH-1:0] win_row;
    logic [LW-1:0] win_col;
    logic          win_ready = 1'b1;

    window_ctrl #(
        .C_KERNEL_WIDTH      (KW),
        .C_KERNEL_HEIGHT     (KH),
        .C_DATAIN_WIDTH      (DW),
        .C_MAX_WINDOW_WIDTH  (64),
        .C_MAX_WINDOW_HEIGHT (64),
        .C_BUF_LATENCY       (LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .cfg_width       (cfg_width),
        .cfg_height      (cfg_height),
        .cfg_stride      (cfg_stride),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .wb_initialize   (wb_initialize),
        .wb_width        (wb_width),
        .wb_datain       (wb_datain),
        .wb_datain_valid (wb_datain_valid),
        .win_valid       (win_valid),
        .win_row         (win_row),
        .win_col         (win_col),
        .win_ready       (win_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Recorders: observed windows (row*256+col), their cycle, forwarded pixels.
    int win_q[$];
    int win_cyc_q[$];
    int dat_q[$];
    int init_cnt = 0;
    int done_cnt = 0;
    int acc_cyc[0:4095];

    always @(negedge clk) begin
        if (win_valid) begin
            win_q.push_back(int'(win_row) * 256 + int'(win_col));
            win_cyc_q.push_back(cyc);
        end
        if (wb_datain_valid) dat_q.push_back(int'(wb_datain));
        if (wb_initialize) init_cnt++;
        if (done) done_cnt++;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        win_q.delete();
        win_cyc_q.delete();
        dat_q.delete();
        init_cnt = 0;
        done_cnt = 0;
    endtask

    // Leaves the bench at the negedge right after the cfg_start cycle.
    task automatic start_frame(input int w, input int h, input int s);
        @(negedge clk);
        cfg_width  = LW'(w);
        cfg_height = LH'(h);
        cfg_stride = 4'(s);
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
    endtask

    // mode 0: steady stream; 1: random gaps + 5-cycle win_ready drop;
    // 2: stray cfg_start mid-frame.
    task automatic stream(input int mode, input int stop_idx, output int idx);
        int  budget;
        int  low_left;
        bit  low_done;
        bit  inj_done;
        bit  acc;
        budget = 0; low_left = 0; low_done = 0; inj_done = 0; idx = 0;
        while (idx < stop_idx && budget < 3000) begin
            budget++;
            pix_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_data  = DW'(idx);
            if (mode == 1 && !low_done && idx == 19) begin
                low_left = 5;
                low_done = 1;
            end
            win_ready = (low_left == 0);
            if (mode == 2 && !inj_done && idx == 10) begin
                cfg_start  = 1'b1;
                cfg_width  = LW'(4);
                cfg_height = LH'(3);
                cfg_stride = 4'd2;
                inj_done   = 1;
            end else begin
                cfg_start = 1'b0;
            end
            #1;
            if (low_left > 0) begin
                check("pix_ready_backpressure", int'(pix_ready), 0);
                low_left--;
            end
            acc = pix_valid && pix_ready;
            if (acc) acc_cyc[idx] = cyc;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        win_ready = 1'b1;
        cfg_start = 1'b0;
        if (budget >= 3000) check("stream_timeout", idx, stop_idx);
    endtask

    task automatic wait_done(output int seen);
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            if (done) seen = 1;
            else @(negedge clk);
        end
    endtask

    // Expected window list built from the stride grid; also checks each
    // window appears LAT+1 cycles after its bottom-right pixel was accepted.
    task automatic check_windows(input string tag, input int w, input int h, input int s);
        int exp_q[$];
        int r, c;
        for (int rr = KH - 1; rr < h; rr += s)
            for (int cc = KW - 1; cc < w; cc += s)
                exp_q.push_back(rr * 256 + cc);
        check({tag, "_win_count"}, win_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < win_q.size(); i++) begin
            check({tag, "_win_pos"}, win_q[i], exp_q[i]);
            r = exp_q[i] / 256;
            c = exp_q[i] % 256;
            check({tag, "_win_latency"}, win_cyc_q[i] - acc_cyc[r * w + c], LAT + 1);
        end
    endtask

    task automatic check_data(input string tag, input int n);
        int bad;
        bad = 0;
        foreach (dat_q[i]) if (dat_q[i] != i) bad++;
        check({tag, "_data_count"}, dat_q.size(), n);
        check({tag, "_data_order"}, bad, 0);
    endtask

    task automatic finish_frame(input string tag, input int w, input int h, input int s);
        int seen;
        wait_done(seen);
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_at_done"}, int'(busy), 0);
        check({tag, "_cfg_err"}, int'(cfg_err), 0);
        repeat (3) @(negedge clk);
        check_windows(tag, w, h, s);
        check_data(tag, w * h);
        check({tag, "_init_pulses"}, init_cnt, 1);
        check({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        int seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs_zero",
              $countones({busy, done, cfg_err, pix_ready, wb_initialize, wb_width, wb_datain,
                          wb_datain_valid, win_valid, win_row, win_col}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: 8x6, stride 1
        clear_rec();
        start_frame(8, 6, 1);
        check("t1_init_pulse", int'(wb_initialize), 1);
        check("t1_busy", int'(busy), 1);
        check("t1_wb_width", int'(wb_width), 8);
        stream(0, 48, idx);
        finish_frame("t1", 8, 6, 1);
        if (win_q.size() > 0) begin
            check("t1_first_win", win_q[0], 2 * 256 + 2);
            check("t1_last_win", win_q[win_q.size() - 1], 5 * 256 + 7);
        end

        // Test 2: stride 2
        clear_rec();
        start_frame(8, 6, 2);
        stream(0, 48, idx);
        finish_frame("t2", 8, 6, 2);

        // Test 3: width below kernel
        clear_rec();
        start_frame(2, 6, 1);
        wait_done(seen);
        check("t3_done_seen", seen, 1);
        check("t3_cfg_err", int'(cfg_err), 1);
        repeat (3) @(negedge clk);
        check("t3_cfg_err_sticky", int'(cfg_err), 1);
        check("t3_datain_valid_count", dat_q.size(), 0);
        check("t3_win_count", win_q.size(), 0);
        check("t3_init_pulses", init_cnt, 0);
        check("t3_done_pulses", done_cnt, 1);

        // Test 4: pixel gaps + consumer back-pressure
        clear_rec();
        start_frame(8, 6, 1);
        check("t4_cfg_err_cleared", int'(cfg_err), 0);
        stream(1, 48, idx);
        finish_frame("t4", 8, 6, 1);

        // Test 5: reset mid-frame at row 3, then a clean frame
        clear_rec();
        start_frame(8, 6, 1);
        stream(0, 27, idx);
        rst = 1'b1;
        @(negedge clk);
        check("t5_reset_outputs_zero",
              $countones({busy, done, cfg_err, pix_ready, wb_initialize, wb_width, wb_datain,
                          wb_datain_valid, win_valid, win_row, win_col}), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_no_done_after_reset", done_cnt, 0);
        clear_rec();
        start_frame(8, 6, 1);
        stream(0, 48, idx);
        finish_frame("t5", 8, 6, 1);

        // Test 6: stray cfg_start during STREAM is ignored
        clear_rec();
        start_frame(8, 6, 1);
        stream(2, 48, idx);
        check("t6_wb_width_kept", int'(wb_width), 8);
        finish_frame("t6", 8, 6, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
